// File: rtl/dt_multi_fz.sv
// Multi-enemy freeze controller: detects player foot-point overlap with enemy hitboxes,
// freezes the player for a timed span, then grants a timed immunity window.
module dt_multi_fz #(
    parameter int N_ENEMY      = 4,
    parameter int XW           = 10,
    parameter int YW           = 9,
    parameter int FOOT_DX      = 24,
    parameter int FOOT_DY      = 41,
    parameter int ENEMY_W      = 62,
    parameter int Y_TOL        = 2,
    parameter int TICK_DIV     = 6000000,
    parameter int FREEZE_TICKS = 15,
    parameter int IMMUNE_TICKS = 8,
    parameter bit RETRIGGER    = 1'b0,
    localparam int IDW         = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XW-1:0]         x_player,
    input  logic [YW-1:0]         y_player,
    input  logic [N_ENEMY*XW-1:0] x_enemy,
    input  logic [N_ENEMY*YW-1:0] y_enemy,
    input  logic [N_ENEMY-1:0]    enemy_en,
    output logic                  frozen,
    output logic                  immune,
    output logic                  hit_pulse,
    output logic [IDW-1:0]        hit_id,
    output logic [7:0]            ticks_left
);

    typedef enum logic [1:0] {IDLE, FROZEN, IMMUNE} state_t;

    localparam int              PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   TICK_LAST   = PW'(TICK_DIV - 1);
    localparam logic [7:0]      FREEZE_LOAD = 8'(FREEZE_TICKS);
    localparam logic [7:0]      IMMUNE_LOAD = 8'(IMMUNE_TICKS);
    localparam logic [XW:0]     EW          = (XW+1)'(ENEMY_W);
    localparam logic [YW:0]     YT          = (YW+1)'(Y_TOL);

    // Foot point carried one bit wider so the window compares never wrap.
    logic [XW:0]          px;
    logic [YW:0]          py;
    logic [N_ENEMY-1:0]   hit;
    logic                 any_hit;
    logic [IDW-1:0]       first_id;
    logic                 tick;

    assign px = {1'b0, x_player} + (XW+1)'(FOOT_DX);
    assign py = {1'b0, y_player} + (YW+1)'(FOOT_DY);

    for (genvar g = 0; g < N_ENEMY; g++) begin : g_hit
        logic [XW:0] xe;
        logic [YW:0] ye;
        assign xe     = {1'b0, x_enemy[g*XW +: XW]};
        assign ye     = {1'b0, y_enemy[g*YW +: YW]};
        assign hit[g] = enemy_en[g] && (xe < px) && (px < xe + EW)
                        && (ye < py + YT) && (py < ye + YT);
    end

    assign any_hit = |hit;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        first_id = '0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (hit[i]) first_id = IDW'(i);
        end
    end

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [7:0]     ticks_q, ticks_d;
    logic           frozen_q, frozen_d;
    logic           immune_q, immune_d;
    logic           pulse_q, pulse_d;
    logic [IDW-1:0] id_q, id_d;

    assign tick = (presc_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        ticks_d = ticks_q;
        pulse_d = 1'b0;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                if (any_hit) begin
                    state_d = FROZEN;
                    ticks_d = FREEZE_LOAD;
                    pulse_d = 1'b1;
                    id_d    = first_id;
                end
            end
            FROZEN: begin
                if (RETRIGGER && any_hit) begin
                    ticks_d = FREEZE_LOAD;
                    presc_d = '0;
                    pulse_d = 1'b1;
                    id_d    = first_id;
                end else if (tick) begin
                    presc_d = '0;
                    if (ticks_q == 8'd1) begin
                        if (IMMUNE_TICKS == 0) begin
                            state_d = IDLE;
                            ticks_d = '0;
                        end else begin
                            state_d = IMMUNE;
                            ticks_d = IMMUNE_LOAD;
                        end
                    end else begin
                        ticks_d = ticks_q - 8'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            IMMUNE: begin
                if (tick) begin
                    presc_d = '0;
                    ticks_d = ticks_q - 8'd1;
                    if (ticks_q == 8'd1) state_d = IDLE;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
                ticks_d = '0;
            end
        endcase
        frozen_d = (state_d == FROZEN);
        immune_d = (state_d == IMMUNE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            ticks_q  <= '0;
            frozen_q <= 1'b0;
            immune_q <= 1'b0;
            pulse_q  <= 1'b0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            ticks_q  <= ticks_d;
            frozen_q <= frozen_d;
            immune_q <= immune_d;
            pulse_q  <= pulse_d;
            id_q     <= id_d;
        end
    end

    assign frozen     = frozen_q;
    assign immune     = immune_q;
    assign hit_pulse  = pulse_q;
    assign hit_id     = id_q;
    assign ticks_left = ticks_q;

endmodule

// File: tb/tb_dt_multi_fz.sv
// Bench for dt_multi_fz: two instances (RETRIGGER 0 and 1) share stimulus and are compared every
// cycle against a span-length model, plus directed literal checks.
module tb_dt_multi_fz;

    localparam int N  = 4;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int TD = 4;
    localparam int FT = 3;
    localparam int IT = 2;

    localparam int M_IDLE   = 0;
    localparam int M_FROZEN = 1;
    localparam int M_IMMUNE = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [XW-1:0]   x_player;
    logic [YW-1:0]   y_player;
    logic [N*XW-1:0] x_enemy;
    logic [N*YW-1:0] y_enemy;
    logic [N-1:0]    enemy_en;

    logic       frozen_a, immune_a, pulse_a;
    logic [1:0] id_a;
    logic [7:0] ticks_a;
    logic       frozen_b, immune_b, pulse_b;
    logic [1:0] id_b;
    logic [7:0] ticks_b;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    dt_multi_fz #(.N_ENEMY(N), .XW(XW), .YW(YW), .TICK_DIV(TD), .FREEZE_TICKS(FT),
                  .IMMUNE_TICKS(IT), .RETRIGGER(1'b0)) dut_a (
        .clk(clk), .rst(rst), .x_player(x_player), .y_player(y_player),
        .x_enemy(x_enemy), .y_enemy(y_enemy), .enemy_en(enemy_en),
        .frozen(frozen_a), .immune(immune_a), .hit_pulse(pulse_a),
        .hit_id(id_a), .ticks_left(ticks_a)
    );

    dt_multi_fz #(.N_ENEMY(N), .XW(XW), .YW(YW), .TICK_DIV(TD), .FREEZE_TICKS(FT),
                  .IMMUNE_TICKS(IT), .RETRIGGER(1'b1)) dut_b (
        .clk(clk), .rst(rst), .x_player(x_player), .y_player(y_player),
        .x_enemy(x_enemy), .y_enemy(y_enemy), .enemy_en(enemy_en),
        .frozen(frozen_b), .immune(immune_b), .hit_pulse(pulse_b),
        .hit_id(id_b), .ticks_left(ticks_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a span is a number of remaining clock cycles; ticks_left is that count in whole ticks.
    int m_mode  [2] = '{0, 0};
    int m_span  [2] = '{0, 0};
    int m_pulse [2] = '{0, 0};
    int m_id    [2] = '{0, 0};

    function automatic int first_hit();
        for (int i = 0; i < N; i++) begin
            int xe, ye, px, py;
            xe = int'(x_enemy[i*XW +: XW]);
            ye = int'(y_enemy[i*YW +: YW]);
            px = int'(x_player) + 24;
            py = int'(y_player) + 41;
            if (enemy_en[i] && xe < px && px < xe + 62 && ye < py + 2 && py < ye + 2)
                return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int h;
        h = first_hit();
        for (int k = 0; k < 2; k++) begin
            m_pulse[k] = 0;
            if (rst) begin
                m_mode[k] = M_IDLE;
                m_span[k] = 0;
                m_id[k]   = 0;
            end else if (m_mode[k] == M_IDLE) begin
                if (h >= 0) begin
                    m_mode[k]  = M_FROZEN;
                    m_span[k]  = FT * TD;
                    m_pulse[k] = 1;
                    m_id[k]    = h;
                end
            end else if (m_mode[k] == M_FROZEN && k == 1 && h >= 0) begin
                m_span[k]  = FT * TD;
                m_pulse[k] = 1;
                m_id[k]    = h;
            end else begin
                m_span[k]--;
                if (m_span[k] == 0) begin
                    if (m_mode[k] == M_FROZEN && IT > 0) begin
                        m_mode[k] = M_IMMUNE;
                        m_span[k] = IT * TD;
                    end else begin
                        m_mode[k] = M_IDLE;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_frozen", frozen_a, m_mode[0] == M_FROZEN);
            check("a_immune", immune_a, m_mode[0] == M_IMMUNE);
            check("a_pulse",  pulse_a,  m_pulse[0]);
            check("a_id",     id_a,     m_id[0]);
            check("a_ticks",  ticks_a,  (m_span[0] + TD - 1) / TD);
            check("b_frozen", frozen_b, m_mode[1] == M_FROZEN);
            check("b_immune", immune_b, m_mode[1] == M_IMMUNE);
            check("b_pulse",  pulse_b,  m_pulse[1]);
            check("b_id",     id_b,     m_id[1]);
            check("b_ticks",  ticks_b,  (m_span[1] + TD - 1) / TD);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_enemy(input int i, input int x, input int y);
        x_enemy[i*XW +: XW] = XW'(x);
        y_enemy[i*YW +: YW] = YW'(y);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return frozen_a;
            1:       return immune_a;
            default: return frozen_b;
        endcase
    endfunction

    task automatic count_high(input int sel, output int n);
        n = 0;
        while (sig(sel) && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((frozen_a | immune_a | frozen_b | immune_b) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("wait_idle_in_budget", c < 200, 1);
    endtask

    initial begin
        int n;
        int c;
        rst      = 1'b1;
        x_player = '0;
        y_player = '0;
        x_enemy  = '0;
        y_enemy  = '0;
        enemy_en = '0;
        step(2);
        cmp_en = 1'b1;
        check("rst_frozen", frozen_a, 0);
        check("rst_ticks",  ticks_a,  0);
        rst = 1'b0;

        // Single hit on channel 2: 12 frozen cycles, 8 immune cycles.
        x_player = 10'd100;
        y_player = 9'd100;
        set_enemy(2, 100, 140);
        enemy_en = 4'b0100;
        step(1);
        check("t1_frozen", frozen_a, 1);
        check("t1_pulse",  pulse_a,  1);
        check("t1_id",     id_a,     2);
        check("t1_ticks",  ticks_a,  3);
        enemy_en = 4'b0000;
        count_high(0, n);
        check("t1_frozen_len", n, 12);
        count_high(1, n);
        check("t1_immune_len", n, 8);
        check("t1_idle_frozen", frozen_a, 0);

        // Strict x-window edges.
        set_enemy(0, 124, 140);
        enemy_en = 4'b0001;
        step(3);
        check("t2_left_edge_no_hit", frozen_a, 0);
        set_enemy(0, 123, 140);
        step(1);
        check("t2_inside_hit", frozen_a, 1);
        check("t2_inside_id",  id_a,     0);
        enemy_en = 4'b0000;
        wait_idle();
        set_enemy(0, 62, 140);
        enemy_en = 4'b0001;
        step(3);
        check("t2_right_edge_no_hit", frozen_a, 0);
        enemy_en = 4'b0000;

        // Right-hand edge of the screen: window end exceeds 10 bits.
        x_player = 10'd990;
        set_enemy(1, 1000, 140);
        enemy_en = 4'b0010;
        step(1);
        check("t3_nowrap_hit", frozen_a, 1);
        check("t3_nowrap_id",  id_a,     1);
        enemy_en = 4'b0000;
        wait_idle();

        // Priority and enable masking.
        x_player = 10'd100;
        set_enemy(1, 100, 140);
        set_enemy(3, 100, 140);
        enemy_en = 4'b1010;
        step(1);
        check("t4_prio_id_a", id_a, 1);
        check("t4_prio_id_b", id_b, 1);
        enemy_en = 4'b0000;
        wait_idle();
        step(3);
        check("t4_disabled_no_hit", frozen_a, 0);
        check("t4_id_held",         id_a,     1);

        // Overlap held through IMMUNE, then refreeze one cycle after IDLE.
        set_enemy(0, 100, 140);
        enemy_en = 4'b0001;
        step(1);
        check("t5_frozen", frozen_a, 1);
        count_high(0, n);
        check("t5_frozen_len", n, 12);
        count_high(1, n);
        check("t5_immune_len", n, 8);
        check("t5_idle_gap", frozen_a, 0);
        step(1);
        check("t5_refreeze",       frozen_a, 1);
        check("t5_refreeze_pulse", pulse_a,  1);
        check("t5_retrig_held",    ticks_b,  3);

        // Retrigger at ticks_left==1 reloads and restarts the prescaler.
        enemy_en = 4'b0000;
        c = 0;
        while (ticks_b != 8'd1 && c < 100) begin
            step(1);
            c++;
        end
        check("t5_reach_tick1", ticks_b, 1);
        enemy_en = 4'b0001;
        step(1);
        check("t5_retrig_ticks", ticks_b, 3);
        check("t5_retrig_pulse", pulse_b, 1);
        enemy_en = 4'b0000;
        count_high(2, n);
        check("t5_retrig_len", n, 12);

        // Reset in the middle of FROZEN.
        wait_idle();
        enemy_en = 4'b0001;
        step(1);
        check("t6_frozen", frozen_a, 1);
        step(3);
        rst = 1'b1;
        step(1);
        check("t6_rst_frozen_a", frozen_a, 0);
        check("t6_rst_pulse_a",  pulse_a,  0);
        check("t6_rst_id_a",     id_a,     0);
        check("t6_rst_ticks_a",  ticks_a,  0);
        check("t6_rst_frozen_b", frozen_b, 0);
        check("t6_rst_immune_b", immune_b, 0);
        rst = 1'b0;
        step(1);
        check("t6_refreeze_a", frozen_a, 1);
        check("t6_refreeze_b", frozen_b, 1);
        enemy_en = 4'b0000;
        wait_idle();
        step(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
